axi4_lite_led_slave: RTL

AXI4-Lite slave register bank that drives the board LEDs. It sits directly downstream of the AXI4-Lite master used by the LED "dance" sequencer and consumes its write transactions, such as 0xAAAA/0x5555 to offset 0x00. It also serves reads and provides an optional hardware blink mode and a write counter for debug.

---
 rtl/axi4_lite_led_slave.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_led_slave.sv
// axi4_lite_led_slave
//   AXI4-Lite register bank driving board LEDs, with optional hardware blink
//   and a count of successful writes.
//
//   Registers (index = ADDR[4:2]):
//     0 LED_VALUE    R/W  low LED_WIDTH bits
//     1 CTRL         R/W  bit0 BLINK_EN
//     2 BLINK_PERIOD R/W  clk cycles per blink half-period (0 behaves as 1)
//     3 WRITE_COUNT  RO   number of OKAY writes
//     4..7 reserved: reads return SLVERR/0, writes return SLVERR
//
//   Ports: clk, resetn (synchronous, active-low), led, and the AXI4-Lite
//   slave channels S_AXI_AW*, S_AXI_W*, S_AXI_B*, S_AXI_AR*, S_AXI_R*.
//
//   Build option: define LED_SLAVE_STRB_EN to honour WSTRB per byte lane on
//   the R/W registers; otherwise every write is a full 32-bit write.
module axi4_lite_led_slave #(
    parameter int          LED_WIDTH     = 16,
    parameter logic [31:0] BLINK_DEFAULT = 32'd25000000
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [LED_WIDTH-1:0] led,
    input  logic [31:0]          S_AXI_AWADDR,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [31:0]          S_AXI_WDATA,
    input  logic [3:0]           S_AXI_WSTRB,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [31:0]          S_AXI_ARADDR,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [31:0]          S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY
);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [LED_WIDTH-1:0] led_value;
    logic                 blink_en;
    logic [31:0]          blink_period, write_count;
    logic [31:0]          blink_cnt;
    logic                 phase;

    // Keeps the ready outputs low until the first edge after reset release.
    logic running;

    logic        aw_held, w_held;
    logic [2:0]  aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    logic        aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data, wr_mask, led_ext, per_eff;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    logic unused;
    assign unused = ^{S_AXI_AWADDR[31:5], S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[31:5], S_AXI_ARADDR[1:0], S_AXI_WSTRB, w_strb};

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    // Commit as soon as both halves are present, arriving now or held earlier.
    assign commit = (w_state == W_IDLE) & (aw_hs | aw_held) & (w_hs | w_held);
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[4:2] : aw_idx;
    assign wr_data = w_hs ? S_AXI_WDATA : w_data;
    assign wr_ok   = (wr_idx < 3'd3);
    assign per_eff = (blink_period == 32'd0) ? 32'd1 : blink_period;

`ifdef LED_SLAVE_STRB_EN
    logic [3:0] wr_strb;
    assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb;
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
`else
    assign wr_mask = 32'hFFFF_FFFF;
`endif

    always_comb begin
        led_ext = '0;
        led_ext[LED_WIDTH-1:0] = led_value;
    end

    // Write FSM
    always_ff @(posedge clk) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (commit) w_next = W_RESP;
            W_RESP: if (S_AXI_BVALID & S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = running & (w_state == W_IDLE) & ~aw_held;
        S_AXI_WREADY  = running & (w_state == W_IDLE) & ~w_held;
    end

    // Read FSM
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (S_AXI_RVALID & S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = running & (r_state == R_IDLE);
    end

    always_comb begin
        rd_data = '0;
        rd_resp = 2'b00;
        case (S_AXI_ARADDR[4:2])
            3'd0:    rd_data = led_ext;
            3'd1:    rd_data = {31'd0, blink_en};
            3'd2:    rd_data = blink_period;
            3'd3:    rd_data = write_count;
            default: rd_resp = 2'b10;
        endcase
    end

    // Channel bookkeeping and response registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            running      <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else begin
            running <= 1'b1;
            if (aw_hs) aw_idx <= S_AXI_AWADDR[4:2];
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (S_AXI_BVALID & S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_resp;
            end else if (S_AXI_RVALID & S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Register bank
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_value    <= '0;
            blink_en     <= 1'b0;
            blink_period <= BLINK_DEFAULT;
            write_count  <= '0;
        end else if (commit && wr_ok) begin
            write_count <= write_count + 32'd1;
            case (wr_idx)
                3'd0: led_value <= LED_WIDTH'((led_ext & ~wr_mask) | (wr_data & wr_mask));
                3'd1: if (wr_mask[0]) blink_en <= wr_data[0];
                3'd2: blink_period <= (blink_period & ~wr_mask) | (wr_data & wr_mask);
                default: ;
            endcase
        end
    end

    // Blink timebase; reprogramming CTRL or PERIOD restarts the on-phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (commit && (wr_idx == 3'd1 || wr_idx == 3'd2)) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_en) begin
            if (blink_cnt >= per_eff - 32'd1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end else begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)               led <= '0;
        else if (blink_en & phase) led <= '0;
        else                       led <= led_value;
    end

endmodule
